// File: rtl/inc_arbiter.sv
// rtl/inc_arbiter.sv - round-robin arbiter sharing one 4-bit incrementer among N_REQ requesters
// Contains the ripple incrementer (inc4) and the arbiter/sequencer top (inc_arbiter).

module inc4 (
  input  logic [3:0] X,
  output logic [3:0] S,
  output logic [3:0] Co
);

  // Half-adder ripple chain with a constant carry-in of 1.
  assign S[0]  = ~X[0];
  assign Co[0] = X[0];

  genvar g;
  generate
    for (g = 1; g < 4; g++) begin : g_bit
      assign S[g]  = X[g] ^ Co[g-1];
      assign Co[g] = X[g] & Co[g-1];
    end
  endgenerate

endmodule

module inc_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   operand,
  output logic [N_REQ-1:0]     ack,
  output logic [3:0]           result,
  output logic                 ovf,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ID_W-1:0]  r_grant_id;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [3:0]       r_op;
  logic [3:0]       r_result;
  logic             r_ovf;
  logic [N_REQ-1:0] r_ack;

  logic             w_any;
  logic [ID_W-1:0]  w_win;
  logic [ID_W-1:0]  w_idx;
  logic [3:0]       w_op;
  logic [3:0]       w_s;
  logic [3:0]       w_co;
  logic [2:0]       w_co_unused;

  // Sum of two in-range indices is below 2*N_REQ, so one subtraction wraps it.
  function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W:0] v);
    if (v >= (ID_W+1)'(N_REQ))
      return ID_W'(v - (ID_W+1)'(N_REQ));
    else
      return ID_W'(v);
  endfunction

  inc4 u_inc (
    .X  (r_op),
    .S  (w_s),
    .Co (w_co)
  );

  assign w_co_unused = w_co[2:0];

  // Descending scan so the smallest offset from rr_ptr is the final winner.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = f_wrap({1'b0, r_rr_ptr} + (ID_W+1)'(k));
      if (req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_comb begin
    w_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant_id == ID_W'(i))
        w_op = operand[4*i +: 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_op       <= '0;
      r_result   <= '0;
      r_ovf      <= 1'b0;
      r_ack      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any)
            r_grant_id <= w_win;
        end
        LOAD: begin
          r_op <= w_op;
        end
        EXEC: begin
          r_result <= w_s;
          r_ovf    <= w_co[3];
          for (int i = 0; i < N_REQ; i++)
            r_ack[i] <= (r_grant_id == ID_W'(i));
        end
        RESP: begin
          r_ack    <= '0;
          r_rr_ptr <= f_wrap({1'b0, r_grant_id} + (ID_W+1)'(1));
        end
        default: begin
          r_ack <= '0;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign result   = r_result;
  assign ovf      = r_ovf;
  assign grant_id = r_grant_id;
  assign busy     = (r_state == LOAD) || (r_state == EXEC);

endmodule

// File: tb/tb_inc_arbiter.sv
// tb/tb_inc_arbiter.sv - directed self-checking bench for inc_arbiter
// Inputs change and outputs are sampled on the falling clock edge.

module tb_inc_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] operand;
  logic [3:0]  ack;
  logic [3:0]  result;
  logic        ovf;
  logic [1:0]  grant_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  inc_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .operand  (operand),
    .ack      (ack),
    .result   (result),
    .ovf      (ovf),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts in IDLE at a falling edge; ends in IDLE at a falling edge.
  task automatic txn(input string tag, input logic [3:0] r, input logic [1:0] id,
                     input logic [3:0] res, input logic o);
    req = r;
    cyc();
    chk({tag, " load busy"}, 8'(busy), 8'h1);
    chk({tag, " grant_id"}, 8'(grant_id), 8'(id));
    chk({tag, " load ack"}, 8'(ack), 8'h0);
    cyc();
    chk({tag, " exec busy"}, 8'(busy), 8'h1);
    chk({tag, " exec ack"}, 8'(ack), 8'h0);
    cyc();
    chk({tag, " ack"}, 8'(ack), 8'(4'b0001 << id));
    chk({tag, " result"}, 8'(result), 8'(res));
    chk({tag, " ovf"}, 8'(ovf), 8'(o));
    chk({tag, " resp busy"}, 8'(busy), 8'h0);
    cyc();
    chk({tag, " ack drop"}, 8'(ack), 8'h0);
    chk({tag, " result hold"}, 8'(result), 8'(res));
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    operand = 16'h0000;
    @(negedge clk);
    cyc();
    chk("rst ack", 8'(ack), 8'h0);
    chk("rst result", 8'(result), 8'h0);
    chk("rst ovf", 8'(ovf), 8'h0);
    chk("rst grant_id", 8'(grant_id), 8'h0);
    chk("rst busy", 8'(busy), 8'h0);
    rst = 1'b0;
    cyc();
    chk("idle busy", 8'(busy), 8'h0);

    operand[3:0] = 4'd3;  txn("op0=3", 4'b0001, 2'd0, 4'd4, 1'b0);
    operand[3:0] = 4'd5;  txn("op0=5", 4'b0001, 2'd0, 4'd6, 1'b0);
    operand[3:0] = 4'd8;  txn("op0=8", 4'b0001, 2'd0, 4'd9, 1'b0);
    operand[3:0] = 4'd10; txn("op0=10", 4'b0001, 2'd0, 4'd11, 1'b0);

    operand[11:8] = 4'hF; txn("op2=F", 4'b0100, 2'd2, 4'h0, 1'b1);
    operand[11:8] = 4'hE; txn("op2=E", 4'b0100, 2'd2, 4'hF, 1'b0);

    // rr_ptr is now 3: requester 0 wins first, then 1.
    operand[3:0] = 4'd6;
    operand[7:4] = 4'd7;
    txn("wrap r0", 4'b0011, 2'd0, 4'd7, 1'b0);
    txn("wrap r1", 4'b0011, 2'd1, 4'd8, 1'b0);
    req = 4'b0000;
    cyc();

    // Reset asserted while in EXEC aborts the request.
    operand[3:0] = 4'd3;
    req = 4'b0001;
    cyc();
    cyc();
    chk("pre-rst exec busy", 8'(busy), 8'h1);
    rst = 1'b1;
    #1;
    chk("async rst ack", 8'(ack), 8'h0);
    chk("async rst result", 8'(result), 8'h0);
    chk("async rst ovf", 8'(ovf), 8'h0);
    chk("async rst busy", 8'(busy), 8'h0);
    chk("async rst grant_id", 8'(grant_id), 8'h0);
    req = 4'b0000;
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    chk("aborted no ack", 8'(ack), 8'h0);
    chk("aborted result", 8'(result), 8'h0);

    operand = {4'd4, 4'd3, 4'd2, 4'd1};
    txn("rr0", 4'b1111, 2'd0, 4'd2, 1'b0);
    txn("rr1", 4'b1111, 2'd1, 4'd3, 1'b0);
    txn("rr2", 4'b1111, 2'd2, 4'd4, 1'b0);
    txn("rr3", 4'b1111, 2'd3, 4'd5, 1'b0);
    txn("rr0b", 4'b1111, 2'd0, 4'd2, 1'b0);
    req = 4'b0000;
    cyc();

    // Operand change after the LOAD edge must not affect the result.
    operand[7:4] = 4'd7;
    req = 4'b0010;
    chk("late idle busy", 8'(busy), 8'h0);
    cyc();
    chk("late load busy", 8'(busy), 8'h1);
    chk("late grant_id", 8'(grant_id), 8'h1);
    cyc();
    operand[7:4] = 4'd9;
    chk("late exec busy", 8'(busy), 8'h1);
    cyc();
    chk("late ack", 8'(ack), 8'b0010);
    chk("late result", 8'(result), 8'd8);
    chk("late resp busy", 8'(busy), 8'h0);
    req = 4'b0000;
    cyc();
    chk("late ack drop", 8'(ack), 8'h0);
    chk("late result hold", 8'(result), 8'd8);
    chk("late idle busy2", 8'(busy), 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
